// File: rtl/div_seq_32bit_pkg.sv
// Shared definitions for the sequential divider: state encoding, default
// width, the divide-by-zero quotient, and the 1-bit full adder cell used
// by the ripple subtractor.
package div_seq_32bit_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Quotient reported when the divisor is zero (all ones).
  localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

  // 1-bit full adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
    full_add = {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
  endfunction

endpackage

// File: rtl/div_seq_32bit_sub_nbit.sv
// N-bit ripple subtractor: a - b computed as a + ~b + 1 through a chain of
// full adder cells. borrow_o is the inverted carry-out, so it is high
// exactly when a < b.
module div_seq_32bit_sub_nbit
  import div_seq_32bit_pkg::*;
#(
  parameter int N = DIV_WIDTH + 1
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_o
);

  logic [N:0] carry;

  // Ripple the carry through one full adder cell per bit, B inverted, Cin=1.
  always_comb begin
    carry    = '0;
    diff_o   = '0;
    carry[0] = 1'b1;
    for (int i = 0; i < N; i++) begin
      {carry[i+1], diff_o[i]} = full_add(a_i[i], ~b_i[i], carry[i]);
    end
  end

  assign borrow_o = ~carry[N];

endmodule

// File: rtl/div_seq_32bit.sv
// Iterative unsigned restoring divider. One quotient bit is produced per
// clock by a trial subtraction of the divisor from the shifted partial
// remainder.
//
// Handshake: Start is sampled only in IDLE; the edge that sees Start=1 in
// IDLE accepts Dividend/Divisor. Busy is high while iterating, Done pulses
// for exactly one cycle when Quotient/Remainder/DivByZero become valid.
// Results hold until the next Done; an accepted Start clears DivByZero at
// once. Start in RUN or DONE is dropped, never queued.
module div_seq_32bit
  import div_seq_32bit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero,
  output logic [1:0]       DbgState
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] q_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;

  logic [WIDTH:0]   trial_a;
  logic [WIDTH:0]   trial_b;
  logic [WIDTH:0]   trial_diff;
  logic             trial_borrow;
  logic [WIDTH:0]   r_d;
  logic [WIDTH-1:0] q_d;

  // The partial remainder stays below the divisor, so its top bit is
  // only ever an intermediate carry bit and is not read back.
  logic             unused_r_top;
  assign unused_r_top = r_q[WIDTH];

  // Shift the next dividend bit into the remainder and try subtracting D.
  assign trial_a = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign trial_b = {1'b0, d_q};

  div_seq_32bit_sub_nbit #(
    .N (WIDTH + 1)
  ) u_sub_nbit (
    .a_i      (trial_a),
    .b_i      (trial_b),
    .diff_o   (trial_diff),
    .borrow_o (trial_borrow)
  );

  // Restore on borrow, otherwise keep the difference; record the quotient bit.
  always_comb begin
    r_d = trial_borrow ? trial_a : trial_diff;
    q_d = {q_q[WIDTH-2:0], ~trial_borrow};
  end

  // Controller, iteration registers and result registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      d_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            if (Divisor != '0) begin
              d_q     <= Divisor;
              r_q     <= '0;
              q_q     <= Dividend;
              cnt_q   <= CW'(WIDTH - 1);
              dbz_q   <= 1'b0;
              state_q <= S_RUN;
            end else begin
              quot_q  <= {WIDTH{1'b1}};
              rem_q   <= Dividend;
              dbz_q   <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_RUN: begin
          r_q <= r_d;
          q_q <= q_d;
          if (cnt_q == '0) begin
            quot_q  <= q_d;
            rem_q   <= r_d[WIDTH-1:0];
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Busy      = (state_q == S_RUN);
  assign Done      = (state_q == S_DONE);
  assign Quotient  = quot_q;
  assign Remainder = rem_q;
  assign DivByZero = dbz_q;
  assign DbgState  = state_q;

endmodule

// File: doc/div_seq_32bit.md
Name: div_seq_32bit

Overview:
- Iterative unsigned restoring divider for the ALU datapath.
- It is the inverse of the ripple-carry adder path: repeated trial subtraction, one quotient bit per clock.
- It sits beside the adder/ALU result mux and takes operands through a Start/Busy/Done handshake.
- It frees the ALU from needing a combinational divide.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- Start  input  1  request a division; sampled only in IDLE.
- Dividend  input  WIDTH  numerator; sampled on the accepting edge.
- Divisor  input  WIDTH  denominator; sampled on the accepting edge.
- Busy  output  1  high while a division is in progress (RUN state).
- Done  output  1  one-cycle pulse when results are valid.
- Quotient  output  WIDTH  unsigned quotient.
- Remainder  output  WIDTH  unsigned remainder.
- DivByZero  output  1  set with Done when Divisor was 0.

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset (Rst_n=0, any time, including mid-RUN): state=IDLE; Busy=0; Done=0; DivByZero=0; Quotient=0; Remainder=0; step counter=0. Any operation in flight is abandoned.
- States:
  - IDLE: waits for Start.
  - RUN: performs WIDTH iterations.
  - DONE: lasts exactly one cycle, then returns to IDLE unconditionally.
- IDLE, Start=1, Divisor!=0 at edge e0:
  - Latch divisor D.
  - Partial remainder R (WIDTH+1 bits) = 0.
  - Quotient shift register Q = Dividend.
  - Counter = WIDTH-1.
  - Go to RUN.
- IDLE, Start=1, Divisor==0 at e0:
  - Go to DONE.
  - Quotient = all ones (2^WIDTH-1); Remainder = Dividend; DivByZero=1.
- RUN, each edge:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} - {1'b0, D}, computed WIDTH+1 bits wide.
  - If T is non-negative (MSB=0): R=T, shift Q left inserting 1.
  - Otherwise: R={R[WIDTH-1:0], Q[WIDTH-1]}, shift Q left inserting 0.
  - When counter==0, go to DONE and copy Q to Quotient and R[WIDTH-1:0] to Remainder. Otherwise decrement the counter.
- Latency:
  - Done=1 in the cycle following edge e0+WIDTH (WIDTH RUN edges). Total start-to-Done is WIDTH edges.
  - Divide-by-zero: Done is high in the cycle after e0 (1 edge).
- Busy=1 exactly while in RUN; Busy=0 in IDLE and DONE.
- Done=1 exactly while in DONE.
- Quotient, Remainder and DivByZero hold their values after Done until the next accepted Start.
  - A new accepted Start clears DivByZero.
  - Quotient and Remainder keep their old values until the new Done.
- Start while in RUN or DONE is ignored. It is not queued. Operand changes during RUN have no effect.
- Start held high continuously: a new division is accepted on the first IDLE edge after DONE. Back-to-back throughput is one result per WIDTH+2 cycles.
- Arithmetic:
  - Unsigned only. Quotient*Divisor+Remainder==Dividend and Remainder<Divisor, for all Divisor!=0.
  - The WIDTH+1-bit subtract covers the case where R's top bit is set, so there is no overflow.

Decomposition:
- Shared ALU package holds:
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - default WIDTH=32;
  - the divide-by-zero quotient constant (all ones).
- One sub-module, sub_nbit:
  - a WIDTH+1-bit ripple subtractor built from the existing 1-bit full adder cell, with B inverted and Cin=1;
  - outputs the difference and a borrow flag (the inverted carry-out).
- The controller and shift registers live in div_seq_32bit.

Test Plan:
- Reset: assert Rst_n=0 mid-RUN (while dividing 1000/7) -> all outputs 0 immediately. After release, Busy stays 0 until a new Start.
- Basic: Dividend=100, Divisor=7, Start pulse -> Busy high for 32 cycles; Done pulse exactly 32 edges after the accepting edge; Quotient=14, Remainder=2, DivByZero=0.
- Extremes:
  - 0xFFFFFFFF/1 -> Q=0xFFFFFFFF, R=0.
  - 5/0xFFFFFFFF -> Q=0, R=5.
  - 0x80000000/0x80000001 -> Q=0, R=0x80000000.
- Divide by zero: Dividend=0x1234, Divisor=0 -> Done one cycle after the accepting edge; Q=0xFFFFFFFF, R=0x1234, DivByZero=1, Busy never high.
- Handshake:
  - Start re-asserted mid-RUN with different operands -> ignored; first result unchanged.
  - Start held high -> second division accepted in the cycle after DONE; results stay stable between Done pulses.
- Random: 1000 random unsigned pairs with Divisor!=0 -> Q*D+R==Dividend and R<D, checked against the reference model.
